// File: rtl/codix_mem_load_ctrl.sv
// Memory-port sequencer for one Codix verification run: image preload, core release,
// core run with a shared memory port, then a streaming post-run memory dump.
module codix_mem_load_ctrl #(
    parameter int unsigned AW         = 16,
    parameter int unsigned DW         = 32,
    parameter int unsigned RESET_HOLD = 4,
    parameter int unsigned DUMP_BASE  = 0,
    parameter int unsigned DUMP_WORDS = 256,
    parameter int unsigned CW         = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          ld_start,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_last,
    input  logic          dump_start,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic [DW-1:0] core_rdata,
    output logic          core_rst_n,
    output logic          mem_ce,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          dump_valid,
    output logic [AW-1:0] dump_addr,
    output logic [DW-1:0] dump_data,
    output logic [CW-1:0] load_cnt,
    output logic          busy,
    output logic          done
);

    localparam int unsigned HOLD_W = (RESET_HOLD > 0) ? $clog2(RESET_HOLD + 1) : 1;
    localparam int unsigned DCNT_W = $clog2(DUMP_WORDS + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRelease,
        StRun,
        StDump,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [DCNT_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [AW-1:0]       rd_addr_q, rd_addr_d;
    logic [CW-1:0]       load_cnt_q, load_cnt_d;
    logic                core_rst_n_q, core_rst_n_d;
    logic                dump_valid_q, dump_valid_d;
    logic [AW-1:0]       dump_addr_q, dump_addr_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= StIdle;
            hold_q       <= '0;
            rd_cnt_q     <= '0;
            rd_addr_q    <= '0;
            load_cnt_q   <= '0;
            core_rst_n_q <= 1'b0;
            dump_valid_q <= 1'b0;
            dump_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            rd_cnt_q     <= rd_cnt_d;
            rd_addr_q    <= rd_addr_d;
            load_cnt_q   <= load_cnt_d;
            core_rst_n_q <= core_rst_n_d;
            dump_valid_q <= dump_valid_d;
            dump_addr_q  <= dump_addr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        rd_cnt_d     = rd_cnt_q;
        rd_addr_d    = rd_addr_q;
        load_cnt_d   = load_cnt_q;
        core_rst_n_d = core_rst_n_q;
        dump_valid_d = 1'b0;
        dump_addr_d  = dump_addr_q;
        ld_ready     = 1'b0;
        core_gnt     = 1'b0;
        mem_ce       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;

        unique case (state_q)
            StIdle, StDone: begin
                core_rst_n_d = 1'b0;
                if (ld_start) begin
                    state_d    = StLoad;
                    load_cnt_d = '0;
                end
            end
            StLoad: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    mem_ce    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = ld_addr;
                    mem_wdata = ld_data;
                    if (load_cnt_q != '1) begin
                        load_cnt_d = load_cnt_q + CW'(1);
                    end
                    if (ld_last) begin
                        state_d = StRelease;
                        hold_d  = HOLD_W'(RESET_HOLD);
                    end
                end
            end
            StRelease: begin
                if (hold_q == '0) begin
                    state_d      = StRun;
                    core_rst_n_d = 1'b1;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            StRun: begin
                // dump_start pre-empts any core access in the same cycle
                if (dump_start) begin
                    state_d      = StDump;
                    core_rst_n_d = 1'b0;
                    rd_cnt_d     = '0;
                    rd_addr_d    = AW'(DUMP_BASE);
                end else begin
                    core_gnt  = core_req;
                    mem_ce    = core_req;
                    mem_we    = core_req & core_we;
                    mem_addr  = core_addr;
                    mem_wdata = core_wdata;
                end
            end
            StDump: begin
                if (rd_cnt_q < DCNT_W'(DUMP_WORDS)) begin
                    mem_ce       = 1'b1;
                    mem_addr     = rd_addr_q;
                    rd_addr_d    = rd_addr_q + AW'(1);
                    rd_cnt_d     = rd_cnt_q + DCNT_W'(1);
                    dump_valid_d = 1'b1;
                    dump_addr_d  = rd_addr_q;
                end else begin
                    // all reads issued; this cycle carries the last read's data
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign core_rdata = mem_rdata;
    assign core_rst_n = core_rst_n_q;
    assign dump_valid = dump_valid_q;
    assign dump_addr  = dump_addr_q;
    assign dump_data  = mem_rdata;
    assign load_cnt   = load_cnt_q;
    assign busy       = (state_q != StIdle) && (state_q != StDone);
    assign done       = (state_q == StDone);

endmodule

// File: tb/tb_codix_mem_load_ctrl.sv
// Directed bench for codix_mem_load_ctrl with a 1-cycle-latency memory model.
module tb_codix_mem_load_ctrl;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    localparam int unsigned HOLD = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          ld_start, ld_valid, ld_ready, ld_last;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          dump_start;
    logic          core_req, core_we, core_gnt, core_rst_n;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata, core_rdata;
    logic          mem_ce, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          dump_valid;
    logic [AW-1:0] dump_addr;
    logic [DW-1:0] dump_data;
    logic [15:0]   load_cnt;
    logic          busy, done;

    int n_total = 0;
    int n_pass  = 0;

    codix_mem_load_ctrl #(
        .AW(AW), .DW(DW), .RESET_HOLD(HOLD), .DUMP_BASE(32'hFFFE), .DUMP_WORDS(4), .CW(16)
    ) dut (
        .CLK(CLK), .RST(RST),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_last(ld_last), .dump_start(dump_start),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rdata(core_rdata),
        .core_rst_n(core_rst_n), .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dump_valid(dump_valid),
        .dump_addr(dump_addr), .dump_data(dump_data), .load_cnt(load_cnt),
        .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    // Memory model: unwritten words read back as {C0DE, address}
    logic [DW-1:0] mem [65536];
    bit            wr_flag [65536];
    always @(posedge CLK) begin
        if (mem_ce) begin
            if (mem_we) begin
                mem[mem_addr]     <= mem_wdata;
                wr_flag[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= wr_flag[mem_addr] ? mem[mem_addr] : {16'hC0DE, mem_addr};
            end
        end
    end

    int            dv_cnt = 0;
    logic [AW-1:0] dq_addr [$];
    logic [DW-1:0] dq_data [$];
    logic [AW-1:0] wq_addr [$];
    logic [DW-1:0] wq_data [$];
    always @(negedge CLK) begin
        if (dump_valid === 1'b1) begin
            dv_cnt++;
            dq_addr.push_back(dump_addr);
            dq_data.push_back(dump_data);
        end
        if (mem_ce === 1'b1 && mem_we === 1'b1) begin
            wq_addr.push_back(mem_addr);
            wq_data.push_back(mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_core_rst(output int n);
        n = 0;
        while (core_rst_n !== 1'b1 && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            step();
            n++;
        end
    endtask

    logic [AW-1:0] exp_a [4];
    int n;

    initial begin
        exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        RST = 1'b0;
        ld_start = 0; ld_valid = 0; ld_last = 0; ld_addr = '0; ld_data = '0;
        dump_start = 0; core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
        #2;
        check("rst_core_rst_n", core_rst_n, 0);
        check("rst_ld_ready", ld_ready, 0);
        check("rst_mem_ce", mem_ce, 0);
        check("rst_busy_done", {busy, done}, 0);
        check("rst_load_cnt", load_cnt, 0);
        check("rst_dump_valid", dump_valid, 0);
        step(); step();
        RST = 1'b1;
        step();

        // Run 1: gapless 4-word load
        ld_start = 1; step(); ld_start = 0;
        check("load_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1; ld_addr = AW'(16'h10 + i); ld_data = DW'(32'hA0 + i);
            ld_last = (i == 3);
            #1;
            check("load_ready", ld_ready, 1);
            check("load_wr", {mem_ce, mem_we, mem_addr, mem_wdata},
                  {2'b11, 16'(16'h10 + i), 32'(32'hA0 + i)});
            step();
        end
        ld_last = 0; ld_addr = 16'h0077; ld_data = 32'h0BAD;
        #1;
        check("release_no_ready", {ld_ready, mem_ce}, 0);
        ld_valid = 0;
        check("load_cnt4", load_cnt, 4);
        wait_core_rst(n);
        check("rst_hold_cycles", n, HOLD + 1);
        for (int i = 0; i < 4; i++) check("mem_img", mem[16'h10 + i], 32'hA0 + i);

        // Core write then read
        core_req = 1; core_we = 1; core_addr = 16'h20; core_wdata = 32'hDEADBEEF;
        #1;
        check("core_wr_gnt", {core_gnt, mem_ce, mem_we, mem_addr, mem_wdata},
              {3'b111, 16'h20, 32'hDEADBEEF});
        step();
        core_we = 0;
        #1;
        check("core_rd_gnt", {core_gnt, mem_ce, mem_we}, 3'b110);
        step();
        core_req = 0;
        #1;
        check("core_rdata", core_rdata, 32'hDEADBEEF);

        // dump_start beats a coincident core request
        core_req = 1; core_addr = 16'h30; dump_start = 1;
        #1;
        check("dump_start_gnt", {core_gnt, mem_ce}, 0);
        step();
        dump_start = 0;
        #1;
        check("dump0_rd", {core_gnt, mem_ce, mem_we, mem_addr}, {3'b010, 16'hFFFE});
        check("dump_core_rst", core_rst_n, 0);
        core_req = 0;
        wait_done(n);
        check("done1", done, 1);
        check("dump_pulses", dv_cnt, 4);
        for (int i = 0; i < 4; i++) begin
            check("dump_addr", i < dq_addr.size() ? dq_addr[i] : 'x, exp_a[i]);
            check("dump_data", i < dq_data.size() ? dq_data[i] : 'x, {16'hC0DE, exp_a[i]});
        end
        step();
        check("done_held", {done, busy}, 2'b10);

        // Run 2: restart from DONE with a 1-word image
        ld_start = 1; step(); ld_start = 0;
        check("rerun_clear", {done, load_cnt}, 0);
        ld_valid = 1; ld_last = 1; ld_addr = 16'hFFFE; ld_data = 32'h12345678;
        step();
        ld_valid = 0; ld_last = 0;
        check("load_cnt1", load_cnt, 1);
        wait_core_rst(n);
        check("rst_hold2", n, HOLD + 1);
        ld_start = 1; step(); ld_start = 0;
        check("run_ignores_start", {busy, core_rst_n, ld_ready, load_cnt}, {3'b110, 16'd1});
        dv_cnt = 0; dq_addr.delete(); dq_data.delete();
        dump_start = 1; step(); dump_start = 0;
        step(); step();
        RST = 1'b0;
        #1;
        check("abort_outs", {dump_valid, mem_ce, mem_we, core_gnt, ld_ready, core_rst_n, busy, done},
              8'h00);
        check("abort_load_cnt", load_cnt, 0);
        step(); step();
        check("abort_pulses", dv_cnt, 1);
        check("abort_data", dq_data.size() > 0 ? dq_data[0] : 'x, 32'h12345678);
        RST = 1'b1;
        step(); step();
        ld_valid = 1; ld_addr = 16'h0050;
        #1;
        check("idle_needs_start", {busy, ld_ready, mem_ce}, 0);
        step();
        ld_valid = 0;

        // Run 3: load with 2-cycle valid gaps
        wq_addr.delete(); wq_data.delete();
        ld_start = 1; step(); ld_start = 0;
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1; ld_addr = AW'(16'h10 + i); ld_data = DW'(32'hA0 + i);
            ld_last = (i == 3);
            step();
            if (i < 3) begin
                for (int g = 0; g < 2; g++) begin
                    ld_valid = 0; ld_addr = 16'h0099; ld_last = 1;
                    #1;
                    check("gap_no_ce", mem_ce, 0);
                    step();
                end
            end
        end
        ld_valid = 0; ld_last = 0;
        check("gap_load_cnt", load_cnt, 4);
        check("gap_writes", wq_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("gap_wr", {i < wq_addr.size() ? wq_addr[i] : 16'hxxxx,
                             i < wq_data.size() ? wq_data[i] : 32'hxxxxxxxx},
                  {16'(16'h10 + i), 32'(32'hA0 + i)});
        end
        wait_core_rst(n);
        check("rst_hold3", n, HOLD + 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/codix_mem_load_ctrl.md
Name: codix_mem_load_ctrl

Overview:
- Sequences the Codix RISC program/data memory through one verification run: preload image → release core → run → post-run memory dump.
- Owns the single memory port. Muxes it between the loader stream (fed from the DPI memory-init side) and the core's data port, then drives readback for comparison against the reference model.
- Holds the core in reset while it owns the memory.

Parameters:
- AW, 16, memory word-address width.
- DW, 32, memory data width.
- RESET_HOLD, 4, cycles core_rst_n stays low after the last load write.
- DUMP_BASE, 0, first word address read during dump.
- DUMP_WORDS, 256, number of words read during dump (≥1).
- CW, 16, load word counter width.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset; asynchronous, active-low.
- ld_start  in  1  pulse; begin image load.
- ld_valid  in  1  loader word valid.
- ld_ready  out  1  controller accepts loader word.
- ld_addr  in  AW  loader word address.
- ld_data  in  DW  loader word data.
- ld_last  in  1  qualifies final loader word.
- dump_start  in  1  pulse; stop core and start dump.
- core_req  in  1  core memory request.
- core_we  in  1  core write enable.
- core_addr  in  AW  core address.
- core_wdata  in  DW  core write data.
- core_gnt  out  1  core request accepted this cycle.
- core_rdata  out  DW  read data to core (1 cycle after grant).
- core_rst_n  out  1  core reset, active-low.
- mem_ce  out  1  memory chip enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid 1 cycle after read mem_ce.
- dump_valid  out  1  dump word valid (one-cycle pulse).
- dump_addr  out  AW  address of dump_data.
- dump_data  out  DW  dumped word.
- load_cnt  out  CW  words written in last load; saturates at 2^CW-1.
- busy  out  1  state is not IDLE or DONE.
- done  out  1  dump complete; held.

Behaviour:
- Reset values (async on RST=0): state IDLE; core_rst_n=0; ld_ready=0; core_gnt=0; mem_ce=0; mem_we=0; dump_valid=0; load_cnt=0; busy=0; done=0. Reset mid-operation aborts immediately; no partial dump_valid is emitted.
- States: IDLE, LOAD, RELEASE, RUN, DUMP, DONE.
- IDLE:
  - ld_start → LOAD; load_cnt cleared.
  - Memory port idle.
- LOAD:
  - ld_ready=1 combinationally.
  - On ld_valid&ld_ready: mem_ce=mem_we=1, mem_addr=ld_addr, mem_wdata=ld_data in the same cycle; load_cnt +1 (saturating).
  - Handshake with ld_last → RELEASE next cycle.
  - ld_valid=0 cycles produce no memory access.
- RELEASE:
  - Down-counter loaded with RESET_HOLD; core_rst_n=0; ld_ready=0.
  - Counter reaches 0 → RUN, with core_rst_n=1 registered on entry.
  - RESET_HOLD=0 passes through in one cycle.
- RUN:
  - Memory mux selects core: mem_ce=core_req, mem_we=core_we, mem_addr/mem_wdata from core; core_gnt=core_req.
  - core_rdata=mem_rdata, unregistered.
  - dump_start → DUMP. dump_start wins over core_req in that cycle: core_gnt=0, mem_ce=0.
  - core_rst_n=0 from the next cycle.
- DUMP:
  - Core held in reset; core_gnt=0.
  - Read i issued at cycle i: mem_ce=1, mem_we=0, mem_addr=(DUMP_BASE+i) mod 2^AW, for i=0..DUMP_WORDS-1, one read per cycle, no gaps.
  - Each read yields dump_valid=1 one cycle later, with dump_addr = read address delayed one cycle and dump_data=mem_rdata.
  - After the final read's data cycle → DONE. Exactly DUMP_WORDS dump_valid pulses.
- DONE:
  - done=1; core_rst_n=0.
  - ld_start → LOAD, clearing done and load_cnt (re-run without reset).
- Ignored inputs:
  - ld_start outside IDLE/DONE.
  - dump_start outside RUN.
  - ld_valid outside LOAD (ld_ready=0, no write).
  - core_req outside RUN (core_gnt=0).
- Simultaneous ld_start and dump_start: only the one legal in the current state acts.
- core_rdata outside RUN is don't-care; the bench must not check it.

Test Plan:
- Load 4 words (addr 0x10..0x13, data 0xA0..0xA3), last on 4th → four mem writes with matching addr/data, load_cnt=4; core_rst_n rises exactly RESET_HOLD+1 cycles after the ld_last handshake.
- Loader inserts 2-cycle ld_valid gaps during LOAD → no mem_ce in gap cycles; memory contents identical to the gapless load.
- RUN: core writes 0xDEADBEEF @0x20, then reads 0x20 → core_gnt same cycle; core_rdata=0xDEADBEEF one cycle after the read grant.
- dump_start coincident with core_req → core_gnt=0 that cycle; with DUMP_BASE=0xFFFE, DUMP_WORDS=4 → dump_addr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001, exactly 4 pulses, then done=1.
- RST asserted in the 3rd DUMP cycle → all outputs return to reset values asynchronously; no further dump_valid; after release, state IDLE and ld_start is required to restart.
- In DONE, ld_start with a new 1-word image → done clears, load_cnt=1, full sequence repeats; ld_start pulses during RUN are ignored.
